// File: rtl/cpu_pkg.sv
// Shared definitions for the writeback stage and its bypass network.
// Contents:
//   ADDR_W / DATA_W : register address and data widths (32 x 32-bit register file)
//   wb_state_e      : halt-tracking state (RUN, HALTING, HALTED)
//   wb_entry_t      : one stage-register entry {dest, data, regwr, halt}
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic              regwr;
        logic              halt;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of every non-clock signal on the writeback stage.
// Signals:
//   in_valid/in_ready/in_dest/in_data/in_regwr/in_halt : result handshake from memory stage
//   write/write_addr/write_data                        : register file write port
//   rd_addr1/2, rf_data1/2, op_data1/2                 : decode read ports and bypassed operands
//   retired, halted                                    : retire count and halt status
// Modports:
//   master : the surrounding pipeline (memory stage, decode, register file)
//   slave  : the writeback stage itself
interface writeback_stage_if #(parameter int CNT_W = 32);
    import cpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data;
    logic              in_regwr;
    logic              in_halt;

    logic              write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] op_data1;
    logic [DATA_W-1:0] op_data2;

    logic [CNT_W-1:0]  retired;
    logic              halted;

    modport master (
        output in_valid, in_dest, in_data, in_regwr, in_halt,
        output rd_addr1, rd_addr2, rf_data1, rf_data2,
        input  in_ready, write, write_addr, write_data,
        input  op_data1, op_data2, retired, halted
    );

    modport slave (
        input  in_valid, in_dest, in_data, in_regwr, in_halt,
        input  rd_addr1, rd_addr2, rf_data1, rf_data2,
        output in_ready, write, write_addr, write_data,
        output op_data1, op_data2, retired, halted
    );

endinterface

// File: rtl/wb_bypass.sv
// Operand bypass for one decode read port.
// Ports:
//   i_write   : register file write enable this cycle
//   i_addr    : register file write address
//   i_data    : register file write data
//   i_rdAddr  : decode read address
//   i_rfData  : value read from the register file array
//   o_opData  : operand handed to decode
module wb_bypass
    import cpu_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_rdAddr,
    input  logic [DATA_W-1:0] i_rfData,
    output logic [DATA_W-1:0] o_opData
);

    // Register 0 reads as zero whatever the array holds; otherwise a pending
    // write to the same register takes priority over the stale array value.
    always_comb begin
        o_opData = i_rfData;
        if (ZERO_REG && (i_rdAddr == '0)) begin
            o_opData = '0;
        end else if (i_write && (i_addr == i_rdAddr)) begin
            o_opData = i_data;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: holds one result from the memory stage for a cycle,
// drives the register file write port from it, bypasses it to decode, counts
// retired instructions and tracks the halt condition.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : asynchronous active-high reset
//   bus    : writeback_stage_if.slave (handshake, write port, read ports, status)
// Parameters:
//   CNT_W    : retire counter width
//   ZERO_REG : 1 makes register 0 hard-wired zero (never written, never bypassed)
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    writeback_stage_if.slave  bus
);

    wb_state_e        r_state;
    logic             r_inReady;
    logic             r_halted;
    logic             r_stValid;
    wb_entry_t        r_st;
    logic [CNT_W-1:0] r_retired;

    logic             w_capture;
    logic             w_zeroDest;
    logic             w_write;
    wb_entry_t        w_entry;

    assign w_capture  = bus.in_valid && r_inReady;
    assign w_zeroDest = ZERO_REG && (r_st.dest == '0);
    assign w_write    = r_stValid && r_st.regwr && !w_zeroDest;

    assign w_entry.dest  = bus.in_dest;
    assign w_entry.data  = bus.in_data;
    assign w_entry.regwr = bus.in_regwr;
    assign w_entry.halt  = bus.in_halt;

    // Stage register. A cycle without a capture leaves a bubble; the payload is
    // held but ignored because r_stValid gates everything downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stValid <= 1'b0;
            r_st      <= '0;
        end else begin
            r_stValid <= w_capture;
            if (w_capture) begin
                r_st <= w_entry;
            end
        end
    end

    // Retire counter: every valid entry leaving the stage counts, halts included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (r_stValid) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Halt FSM. HALTING covers the one cycle in which the halt entry sits in the
    // stage register, so halted only rises once that entry has been counted.
    // in_ready and halted are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_inReady <= 1'b1;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_capture && bus.in_halt) begin
                        r_state   <= HALTING;
                        r_inReady <= 1'b0;
                    end
                end
                HALTING: begin
                    r_state  <= HALTED;
                    r_halted <= 1'b1;
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state   <= RUN;
                    r_inReady <= 1'b1;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_inReady;
    assign bus.halted     = r_halted;
    assign bus.retired    = r_retired;
    assign bus.write      = w_write;
    assign bus.write_addr = r_st.dest;
    assign bus.write_data = r_st.data;

    wb_bypass #(.ZERO_REG(ZERO_REG)) u_bypass1 (
        .i_write  (w_write),
        .i_addr   (r_st.dest),
        .i_data   (r_st.data),
        .i_rdAddr (bus.rd_addr1),
        .i_rfData (bus.rf_data1),
        .o_opData (bus.op_data1)
    );

    wb_bypass #(.ZERO_REG(ZERO_REG)) u_bypass2 (
        .i_write  (w_write),
        .i_addr   (r_st.dest),
        .i_data   (r_st.data),
        .i_rdAddr (bus.rd_addr2),
        .i_rfData (bus.rf_data2),
        .o_opData (bus.op_data2)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage. A main instance (CNT_W=32) is wired
// to a small register file array; a second instance (CNT_W=4) exercises the
// retire counter wrap.
module tb_writeback_stage;
    import cpu_pkg::*;

    logic clk;
    logic reset;

    int total;
    int bad;

    logic [DATA_W-1:0] rf [32];

    writeback_stage_if #(.CNT_W(32)) wbIf ();
    writeback_stage_if #(.CNT_W(4))  narrowIf ();

    writeback_stage #(.CNT_W(32), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wbIf.slave)
    );

    writeback_stage #(.CNT_W(4), .ZERO_REG(1'b1)) dutNarrow (
        .clk   (clk),
        .reset (reset),
        .bus   (narrowIf.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file array that the stage writes into; read combinationally.
    always @(posedge clk) begin
        if (wbIf.write) begin
            rf[wbIf.write_addr] <= wbIf.write_data;
        end
    end

    assign wbIf.rf_data1     = rf[wbIf.rd_addr1];
    assign wbIf.rf_data2     = rf[wbIf.rd_addr2];
    assign narrowIf.rf_data1 = '0;
    assign narrowIf.rf_data2 = '0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one result to the main instance and step to 1 time unit past the next edge.
    task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] dest,
                                 input logic [DATA_W-1:0] data, input logic regwr,
                                 input logic halt);
        wbIf.in_valid = valid;
        wbIf.in_dest  = dest;
        wbIf.in_data  = data;
        wbIf.in_regwr = regwr;
        wbIf.in_halt  = halt;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge with all inputs idle.
    task automatic resetDut();
        wbIf.in_valid     = 1'b0;
        wbIf.in_halt      = 1'b0;
        narrowIf.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'h100 + 32'(i);
        end
        wbIf.in_valid = 1'b0;
        wbIf.in_dest  = '0;
        wbIf.in_data  = '0;
        wbIf.in_regwr = 1'b0;
        wbIf.in_halt  = 1'b0;
        wbIf.rd_addr1 = '0;
        wbIf.rd_addr2 = '0;
        narrowIf.in_valid = 1'b0;
        narrowIf.in_dest  = 5'd4;
        narrowIf.in_data  = 32'hA5;
        narrowIf.in_regwr = 1'b1;
        narrowIf.in_halt  = 1'b0;
        narrowIf.rd_addr1 = '0;
        narrowIf.rd_addr2 = '0;
        reset = 1'b1;
        #12;
        reset = 1'b0;

        // Reset state
        checkOutput("rst write",   32'(wbIf.write),    32'd0);
        checkOutput("rst halted",  32'(wbIf.halted),   32'd0);
        checkOutput("rst inReady", 32'(wbIf.in_ready), 32'd1);
        checkOutput("rst retired", wbIf.retired,       32'd0);

        // Reset mid-write: the pending write vanishes and reg3 keeps its value
        resetDut();
        wbIf.rd_addr1 = 5'd3;
        applyStimulus(1'b1, 5'd3, 32'hDEAD, 1'b1, 1'b0);
        checkOutput("t1 write before rst", 32'(wbIf.write), 32'd1);
        wbIf.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1 write async drop", 32'(wbIf.write), 32'd0);
        checkOutput("t1 retired",          wbIf.retired,    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t1 reg3 unchanged", wbIf.op_data1, 32'h103);

        // Write then read: bypass during the write cycle, array afterwards
        wbIf.rd_addr1 = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);
        checkOutput("t2 write",       32'(wbIf.write), 32'd1);
        checkOutput("t2 write_addr",  32'(wbIf.write_addr), 32'd5);
        checkOutput("t2 rf still old", wbIf.rf_data1,  32'h105);
        checkOutput("t2 bypass",      wbIf.op_data1,   32'h1234);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("t2 write idle",  32'(wbIf.write), 32'd0);
        checkOutput("t2 rf updated",  wbIf.op_data1,   32'h1234);

        // Register 0 is never written and reads as zero
        wbIf.rd_addr1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checkOutput("t3 write r0", 32'(wbIf.write), 32'd0);
        checkOutput("t3 read r0",  wbIf.op_data1,   32'd0);

        // Back-to-back writes to r7 with port 2 watching
        resetDut();
        wbIf.rd_addr2 = 5'd7;
        applyStimulus(1'b1, 5'd7, 32'd1, 1'b1, 1'b0);
        checkOutput("t4 wdata 1",  wbIf.write_data, 32'd1);
        checkOutput("t4 bypass 1", wbIf.op_data2,   32'd1);
        applyStimulus(1'b1, 5'd7, 32'd2, 1'b1, 1'b0);
        checkOutput("t4 wdata 2",  wbIf.write_data, 32'd2);
        checkOutput("t4 bypass 2", wbIf.op_data2,   32'd2);
        applyStimulus(1'b1, 5'd7, 32'd3, 1'b1, 1'b0);
        checkOutput("t4 wdata 3",  wbIf.write_data, 32'd3);
        checkOutput("t4 bypass 3", wbIf.op_data2,   32'd3);
        checkOutput("t4 retired 2", wbIf.retired,   32'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("t4 retired 3", wbIf.retired,   32'd3);
        checkOutput("t4 rf r7",     wbIf.op_data2,  32'd3);

        // Halt after two results; later inputs are refused
        resetDut();
        wbIf.rd_addr1 = 5'd9;
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
        checkOutput("t5 ready before halt", 32'(wbIf.in_ready), 32'd1);
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 1'b1);
        checkOutput("t5 ready after halt",  32'(wbIf.in_ready), 32'd0);
        checkOutput("t5 halted early",      32'(wbIf.halted),   32'd0);
        checkOutput("t5 retired 2",         wbIf.retired,       32'd2);
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        checkOutput("t5 halted",            32'(wbIf.halted),   32'd1);
        checkOutput("t5 retired 3",         wbIf.retired,       32'd3);
        checkOutput("t5 no write",          32'(wbIf.write),    32'd0);
        applyStimulus(1'b1, 5'd9, 32'h98, 1'b1, 1'b0);
        checkOutput("t5 retired held",      wbIf.retired,       32'd3);
        checkOutput("t5 still no write",    32'(wbIf.write),    32'd0);
        checkOutput("t5 r9 untouched",      wbIf.op_data1,      32'h109);
        checkOutput("t5 halted sticky",     32'(wbIf.halted),   32'd1);
        wbIf.in_valid = 1'b0;

        // Retire counter wrap on the 4-bit instance
        resetDut();
        narrowIf.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
        end
        #1;
        narrowIf.in_valid = 1'b0;
        checkOutput("t6 retired 16", 32'(narrowIf.retired), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t6 retired 17", 32'(narrowIf.retired), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
